lsu: RTL and testbench

Load/store unit: the initiating side of the CPU's data-memory port. Accepts one load or store request at a time from the execute stage, computes the effective address, and drives the `dmem` port (`we_dmem`, `is_LOAD`, `dmem_word_sel`, `r_dmem_addr`, `w_dmem_data`, `func3`). It captures `dmem_data` and any `dmem` exception, and returns one registered response per request through a valid/ready handshake.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/lsu_fmt.sv | 54 +++++
 rtl/lsu.sv | 181 ++++++++++++++++++
 tb/tb_lsu.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared data-memory definitions: func3 encodings, byte-select masks, exception causes and LSU states.
// Used by lsu and lsu_fmt; the split-access option is controlled by LSU_MISALIGN_EN in lsu.sv.
package mem_pkg;

  localparam logic [63:0] DMEM_BASE = 64'h8000_0000;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [7:0] SEL_B = 8'b0000_0001;
  localparam logic [7:0] SEL_H = 8'b0000_0011;
  localparam logic [7:0] SEL_W = 8'b0000_1111;
  localparam logic [7:0] SEL_D = 8'b1111_1111;

  localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic [3:0] misalign_code(input logic store);
    return store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational access formatter: access size and byte-select from func3, alignment check,
// and sign/zero extension of right-aligned load data.
module lsu_fmt
  import mem_pkg::*;
(
  input  logic [1:0]  size_code,
  input  logic [2:0]  addr_lo,
  input  logic [2:0]  ext_func3,
  input  logic [63:0] raw,
  output logic [3:0]  size,
  output logic [7:0]  word_sel,
  output logic        misaligned,
  output logic [63:0] ext_data
);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    size       = 4'd1;
    word_sel   = SEL_B;
    misaligned = 1'b0;
    case (size_code)
      2'b01: begin
        size       = 4'd2;
        word_sel   = SEL_H;
        misaligned = addr_lo[0];
      end
      2'b10: begin
        size       = 4'd4;
        word_sel   = SEL_W;
        misaligned = |addr_lo[1:0];
      end
      2'b11: begin
        size       = 4'd8;
        word_sel   = SEL_D;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    ext_data = raw;
    case (ext_func3)
      F3_B:    ext_data = {{56{raw[7]}},  raw[7:0]};
      F3_H:    ext_data = {{48{raw[15]}}, raw[15:0]};
      F3_W:    ext_data = {{32{raw[31]}}, raw[31:0]};
      F3_BU:   ext_data = {56'd0, raw[7:0]};
      F3_HU:   ext_data = {48'd0, raw[15:0]};
      F3_WU:   ext_data = {32'd0, raw[31:0]};
      default: ext_data = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP, registered response with valid/ready.
// Define LSU_MISALIGN_EN to split misaligned accesses into byte accesses instead of trapping them.
module lsu
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_load,
  input  logic            req_is_store,
  input  logic [2:0]      req_func3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_exc_en,
  output logic [3:0]      resp_exc_code,
  output logic [XLEN-1:0] resp_exc_val,
  output logic            we_dmem,
  output logic            is_LOAD,
  output logic [7:0]      dmem_word_sel,
  output logic [XLEN-1:0] r_dmem_addr,
  output logic [XLEN-1:0] w_dmem_data,
  output logic [2:0]      func3,
  input  logic [XLEN-1:0] dmem_data,
  input  logic            exc_en,
  input  logic [3:0]      exc_code,
  input  logic [XLEN-1:0] exc_val
);

  state_t          state, state_next;
  logic [XLEN-1:0] ea, wdata, asm_data;
  logic [2:0]      f3, cnt;
  logic            op_store, split;

  logic [XLEN-1:0] ea_req, asm_next, ext_raw, ext_data;
  logic [3:0]      size;
  logic [7:0]      sel;
  logic            legal, mis, mis_trap, split_req, last;

  // The memory reports its own faulting address; the response always carries the effective address.
  logic unused_exc_val;
  assign unused_exc_val = ^exc_val;

  assign ea_req = req_base + req_imm;
  assign legal  = (req_is_load ^ req_is_store)
                && !(req_is_load && req_func3 == F3_BAD)
                && !(req_is_store && req_func3[2]);

`ifdef LSU_MISALIGN_EN
  assign mis_trap  = 1'b0;
  assign split_req = mis;
`else
  assign mis_trap  = mis;
  assign split_req = 1'b0;
`endif

  assign asm_next = asm_data | ({{(XLEN-8){1'b0}}, dmem_data[7:0]} << {cnt, 3'b000});
  assign ext_raw  = split ? asm_next : dmem_data;
  assign last     = ({1'b0, cnt} == size - 4'd1);

  lsu_fmt u_fmt (
    .size_code  (state == S_IDLE ? req_func3[1:0] : f3[1:0]),
    .addr_lo    (ea_req[2:0]),
    .ext_func3  (f3),
    .raw        (ext_raw),
    .size       (size),
    .word_sel   (sel),
    .misaligned (mis),
    .ext_data   (ext_data)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    we_dmem       = 1'b0;
    is_LOAD       = 1'b0;
    dmem_word_sel = '0;
    r_dmem_addr   = '0;
    w_dmem_data   = '0;
    func3         = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (!legal || mis_trap) ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        we_dmem = op_store;
        is_LOAD = !op_store;
        if (split) begin
          dmem_word_sel = SEL_B;
          r_dmem_addr   = ea + {{(XLEN-3){1'b0}}, cnt};
          w_dmem_data   = wdata >> {cnt, 3'b000};
          func3         = op_store ? F3_B : F3_BU;
          if (exc_en || last) state_next = S_RESP;
        end else begin
          dmem_word_sel = sel;
          r_dmem_addr   = ea;
          w_dmem_data   = wdata;
          func3         = f3;
          state_next    = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ea            <= '0;
      wdata         <= '0;
      asm_data      <= '0;
      f3            <= '0;
      cnt           <= '0;
      op_store      <= 1'b0;
      split         <= 1'b0;
      resp_data     <= '0;
      resp_exc_en   <= 1'b0;
      resp_exc_code <= '0;
      resp_exc_val  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          ea            <= ea_req;
          f3            <= req_func3;
          op_store      <= req_is_store;
          wdata         <= req_wdata;
          cnt           <= '0;
          asm_data      <= '0;
          split         <= split_req;
          resp_data     <= '0;
          resp_exc_en   <= 1'b0;
          resp_exc_code <= '0;
          resp_exc_val  <= '0;
          if (!legal) begin
            resp_exc_en   <= 1'b1;
            resp_exc_code <= EXC_ILLEGAL;
          end else if (mis_trap) begin
            resp_exc_en   <= 1'b1;
            resp_exc_code <= misalign_code(req_is_store);
            resp_exc_val  <= ea_req;
          end
        end
        S_ACCESS: begin
          if (exc_en) begin
            resp_exc_en   <= 1'b1;
            resp_exc_code <= exc_code;
            resp_exc_val  <= ea;
            resp_data     <= '0;
          end else if (!split || last) begin
            resp_exc_en   <= 1'b0;
            resp_exc_code <= '0;
            resp_exc_val  <= '0;
            resp_data     <= op_store ? '0 : ext_data;
          end else begin
            cnt      <= cnt + 3'd1;
            asm_data <= asm_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array data memory on the dmem port, directed cases plus random
// requests checked against a byte-level reference model of the load/store rules.
module tb_lsu;
  import mem_pkg::*;

  localparam int MEM_BYTES = 16384;
`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  req_func3;
  logic [63:0] req_base, req_imm, req_wdata;
  logic        resp_valid, resp_ready, resp_exc_en;
  logic [63:0] resp_data, resp_exc_val;
  logic [3:0]  resp_exc_code;
  logic        we_dmem, is_LOAD;
  logic [7:0]  dmem_word_sel;
  logic [63:0] r_dmem_addr, w_dmem_data;
  logic [2:0]  func3;
  logic [63:0] dmem_data, exc_val;
  logic        exc_en;
  logic [3:0]  exc_code;

  always #5 clk = ~clk;

  lsu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_is_store(req_is_store), .req_func3(req_func3),
    .req_base(req_base), .req_imm(req_imm), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_exc_en(resp_exc_en), .resp_exc_code(resp_exc_code), .resp_exc_val(resp_exc_val),
    .we_dmem(we_dmem), .is_LOAD(is_LOAD), .dmem_word_sel(dmem_word_sel),
    .r_dmem_addr(r_dmem_addr), .w_dmem_data(w_dmem_data), .func3(func3),
    .dmem_data(dmem_data), .exc_en(exc_en), .exc_code(exc_code), .exc_val(exc_val)
  );

  logic [7:0] mem     [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  logic       mem_init;
  int         total = 0;
  int         bad   = 0;

  logic [63:0] last_data, last_val;
  logic [3:0]  last_code;
  logic        last_exc;
  int          last_lat, last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int sel_size(input logic [7:0] s);
    case (s)
      8'h01:   return 1;
      8'h03:   return 2;
      8'h0F:   return 4;
      8'hFF:   return 8;
      default: return 0;
    endcase
  endfunction

  function automatic bit in_range(input logic [63:0] a, input int n);
    logic [63:0] off;
    off = a - DMEM_BASE;
    return (off < 64'(MEM_BYTES)) && (off + 64'(n) <= 64'(MEM_BYTES));
  endfunction

  // Memory reply: right-aligned read data, access fault outside the DMEM window.
  always_comb begin
    int n;
    n         = sel_size(dmem_word_sel);
    dmem_data = '0;
    exc_en    = 1'b0;
    exc_code  = '0;
    exc_val   = '0;
    if (we_dmem || is_LOAD) begin
      if (!in_range(r_dmem_addr, n)) begin
        exc_en   = 1'b1;
        exc_code = we_dmem ? EXC_ST_FAULT : EXC_LD_FAULT;
        exc_val  = r_dmem_addr;
      end else if (is_LOAD) begin
        for (int i = 0; i < n; i++) dmem_data[8*i +: 8] = mem[int'(r_dmem_addr[13:0]) + i];
      end
    end
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
      for (int i = 0; i < 16; i++) mem[16'h2000 + i] <= (i % 2 == 0) ? 8'hFF : 8'h00;
    end else if (we_dmem && !exc_en) begin
      for (int i = 0; i < sel_size(dmem_word_sel); i++)
        mem[int'(r_dmem_addr[13:0]) + i] <= w_dmem_data[8*i +: 8];
    end
  end

  // Reference model: applies the access rules to ref_mem and predicts the response.
  task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [63:0] ea, input logic [63:0] wd,
                       output logic [63:0] e_data, output logic e_exc, output logic [3:0] e_code,
                       output logic [63:0] e_val, output int e_lat, output int e_acc);
    int          sz;
    bit          mis;
    logic [63:0] raw;
    sz     = 1 << f3[1:0];
    mis    = (ea % 64'(sz)) != 0;
    e_data = '0; e_exc = 1'b0; e_code = '0; e_val = '0; e_lat = 1; e_acc = 0;
    raw    = '0;
    if (ld == st || (ld && f3 == 3'b111) || (st && f3[2])) begin
      e_exc = 1'b1; e_code = 4'd2;
      return;
    end
    if (mis && !SPLIT) begin
      e_exc = 1'b1; e_code = ld ? 4'd4 : 4'd6; e_val = ea;
      return;
    end
    for (int i = 0; i < sz; i++) begin
      if (mis) begin
        e_acc = i + 1; e_lat = i + 2;
      end else begin
        e_acc = 1; e_lat = 2;
      end
      if (!(mis ? in_range(ea + 64'(i), 1) : in_range(ea, sz))) begin
        e_exc = 1'b1; e_code = ld ? 4'd5 : 4'd7; e_val = ea;
        return;
      end
      if (ld) raw[8*i +: 8] = ref_mem[int'(ea[13:0]) + i];
      else    ref_mem[int'(ea[13:0]) + i] = wd[8*i +: 8];
    end
    if (ld) begin
      e_data = raw;
      if (!f3[2] && sz < 8 && raw[8*sz-1]) e_data = raw | ~((64'd1 << (8*sz)) - 64'd1);
    end
  endtask

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [63:0] base, input logic [63:0] imm,
                        input logic [63:0] wd, input int hold);
    logic [63:0] ea, e_data, e_val, mask, a, got_m, exp_m;
    logic        e_exc;
    logic [3:0]  e_code;
    int          e_lat, e_acc, lat, acc, sz, n;
    bit          split_exp;
    ea = base + imm;
    sz = 1 << f3[1:0];
    split_exp = (ea % 64'(sz)) != 0;
    mask = (sz == 8) ? '1 : ((64'd1 << (8*sz)) - 64'd1);
    model(ld, st, f3, ea, wd, e_data, e_exc, e_code, e_val, e_lat, e_acc);

    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_is_load = ld; req_is_store = st; req_func3 = f3;
    req_base = base; req_imm = imm; req_wdata = wd;
    resp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_is_load = 1'($urandom); req_is_store = 1'($urandom);
    req_func3 = 3'($urandom);

    lat = 99; acc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        break;
      end
      if (we_dmem || is_LOAD) begin
        check("port_is_load", is_LOAD, ld);
        check("port_we", we_dmem, st);
        if (split_exp) begin
          check("port_addr", r_dmem_addr, ea + 64'(acc));
          check("port_sel", dmem_word_sel, 8'h01);
          check("port_func3", func3, ld ? 3'b100 : 3'b000);
          if (st) check("port_wbyte", w_dmem_data[7:0], wd[8*acc +: 8]);
        end else begin
          check("port_addr", r_dmem_addr, ea);
          check("port_sel", dmem_word_sel, mask[7:0] & 8'hFF & ((8'd1 << sz) - 8'd1));
          check("port_func3", func3, f3);
          if (st) check("port_wdata", w_dmem_data & mask, wd & mask);
        end
        acc++;
      end else begin
        check("port_quiet", {dmem_word_sel, func3} | 11'(r_dmem_addr != 0) | 11'(w_dmem_data != 0), '0);
      end
    end
    check("latency", 64'(lat), 64'(e_lat));
    check("accesses", 64'(acc), 64'(e_acc));
    check("resp_port_quiet", {we_dmem, is_LOAD, dmem_word_sel, func3}, '0);
    check("req_ready_busy", req_ready, 1'b0);
    check("resp_data", resp_data, e_data);
    check("resp_exc_en", resp_exc_en, e_exc);
    check("resp_exc_code", resp_exc_code, e_code);
    check("resp_exc_val", resp_exc_val, e_val);
    last_data = resp_data; last_exc = resp_exc_en; last_code = resp_exc_code;
    last_val = resp_exc_val; last_lat = lat; last_acc = acc;

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_data", resp_data, e_data);
      check("hold_code", {resp_exc_en, resp_exc_code}, {e_exc, e_code});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'($urandom);
    @(negedge clk);
    check("resp_released", resp_valid, 1'b0);
    check("req_ready_back", req_ready, 1'b1);

    a = in_range(ea, 8) ? ea : DMEM_BASE;
    for (int i = 0; i < 8; i++) begin
      got_m[8*i +: 8] = mem[int'(a[13:0]) + i];
      exp_m[8*i +: 8] = ref_mem[int'(a[13:0]) + i];
    end
    check("memory", got_m, exp_m);
  endtask

  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [63:0] base, imm;
    int          r, v;

    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_is_load = 1'b0; req_is_store = 1'b0; req_func3 = '0;
    req_base = '0; req_imm = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) ref_mem[16'h2000 + i] = (i % 2 == 0) ? 8'hFF : 8'h00;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp", {resp_exc_en, resp_exc_code} | 5'(resp_data != 0) | 5'(resp_exc_val != 0), '0);
    check("rst_dmem", {we_dmem, is_LOAD, dmem_word_sel, func3}, '0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1, 0, F3_B, 64'h8000_2000, 0, 0, 0);
    check("tp_lb", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("tp_lb_lat", 64'(last_lat), 64'd2);
    run_op(1, 0, F3_BU, 64'h8000_2000, 0, 0, 1);
    check("tp_lbu", last_data, 64'h0000_0000_0000_00FF);
    run_op(0, 1, F3_D, 64'h8000_0000, 64'h100, 64'h1122_3344_5566_7788, 0);
    run_op(1, 0, F3_D, 64'h8000_0100, 0, 0, 0);
    check("tp_ld", last_data, 64'h1122_3344_5566_7788);
    run_op(1, 0, F3_W, 64'h8000_0108, -64'sd4, 0, 2);
    check("tp_lw", last_data, 64'h0000_0000_1122_3344);
    run_op(1, 0, F3_W, 64'h8000_2001, 0, 0, 0);
`ifdef LSU_MISALIGN_EN
    check("tp_lw_split", last_data, 64'hFFFF_FFFF_FF00_FF00);
    check("tp_lw_split_lat", 64'(last_lat), 64'd5);
`else
    check("tp_lw_mis_code", {last_exc, last_code}, {1'b1, 4'd4});
    check("tp_lw_mis_val", last_val, 64'h8000_2001);
    check("tp_lw_mis_acc", 64'(last_acc), 64'd0);
`endif
    run_op(0, 1, F3_D, 64'h7FFF_FFF8, 0, 64'hDEAD_BEEF_0000_0001, 0);
    check("tp_sd_fault", {last_exc, last_code}, {1'b1, 4'd7});
    check("tp_sd_fault_val", last_val, 64'h7FFF_FFF8);
    run_op(1, 0, F3_D, 64'h8000_4000, 0, 0, 0);
    check("tp_ld_fault", {last_exc, last_code}, {1'b1, 4'd5});
    run_op(1, 1, F3_D, 64'h8000_0000, 0, 0, 0);
    check("tp_both", {last_exc, last_code, 4'(last_acc)}, {1'b1, 4'd2, 4'd0});
    run_op(1, 0, F3_BAD, 64'h8000_0000, 0, 0, 0);
    check("tp_f3_111", {last_exc, last_code}, {1'b1, 4'd2});
    run_op(1, 0, F3_D, 64'h8000_0100, 0, 0, 4);
    check("tp_hold4", last_data, 64'h1122_3344_5566_7788);

    // Reset in the middle of a store's ACCESS cycle must suppress the write.
    req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1; req_func3 = F3_D;
    req_base = 64'h8000_0200; req_imm = 0; req_wdata = 64'hCAFE_F00D_1234_5678; resp_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_we", we_dmem, 1'b1);
    rst = 1'b1;
    #2;
    check("rst_mid_we_drop", we_dmem, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", req_ready, 1'b1);
    check("rst_mid_valid", resp_valid, 1'b0);
    check("rst_mid_resp", resp_data, 64'd0);
    check("rst_mid_mem", {mem[16'h200], mem[16'h201], mem[16'h207]}, {ref_mem[16'h200], ref_mem[16'h201], ref_mem[16'h207]});
    check("rst_mid_mem0", {mem[16'h200], mem[16'h203]}, 16'h0000);

    for (int t = 0; t < 200; t++) begin
      r  = int'($urandom_range(0, 9));
      ld = (r < 5) ? 1'b1 : (r < 9) ? 1'b0 : 1'($urandom);
      st = (r < 5) ? 1'b0 : (r < 9) ? 1'b1 : ld;
      f3 = 3'($urandom_range(0, 7));
      if (st && !ld && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      case ($urandom_range(0, 9))
        0:       base = 64'h7FFF_FFF0 + 64'($urandom_range(0, 15));
        1:       base = DMEM_BASE + 64'(MEM_BYTES - 8);
        default: base = DMEM_BASE + 64'($urandom_range(0, 255));
      endcase
      v   = int'($urandom_range(0, 32)) - 16;
      imm = longint'(v);
      run_op(ld, st, f3, base, imm, {$urandom, $urandom}, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
